// File: rtl/wm_led_panel.sv
// rtl/wm_led_panel.sv - washing-machine front panel: debounce, programme selection, run/pause FSM, LED drive
module wm_led_panel #(
    parameter int N_STAGES       = 4,
    parameter int N_LEVELS       = 3,
    parameter int N_TEMPS        = 3,
    parameter int DEBOUNCE_CYC   = 250000,
    parameter int BLINK_HALF_CYC = 62500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_stage,
    input  logic                btn_level,
    input  logic                btn_temp,
    input  logic                btn_start,
    input  logic [N_STAGES-1:0] run_stage,
    input  logic                run_done,
    output logic [N_STAGES-1:0] red_led_stage,
    output logic                red_led_water_height,
    output logic                red_led_hot_cold,
    output logic [N_LEVELS-1:0] green_led_level,
    output logic [N_TEMPS-1:0]  green_led_temp,
    output logic [N_STAGES-1:0] sel_stage_mask,
    output logic                start_pulse,
    output logic                pause
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int BL_W = $clog2(BLINK_HALF_CYC);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // button index: 0 stage, 1 level, 2 temp, 3 start
    logic [3:0]      btn;
    logic [3:0]      press;
    logic [DB_W-1:0] db_cnt [4];

    assign btn = {btn_start, btn_temp, btn_level, btn_stage};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                db_cnt[i] <= '0;
                press[i]  <= 1'b0;
            end else begin
                press[i] <= btn[i] && (db_cnt[i] == DB_LAST);
                if (!btn[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_MAX)
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
        end
    end

    state_t              state, nxt_state;
    logic [BL_W-1:0]     blink_cnt, nxt_blink_cnt;
    logic                phase, nxt_phase;
    logic [N_STAGES-1:0] nxt_mask;
    logic [N_LEVELS-1:0] nxt_level;
    logic [N_TEMPS-1:0]  nxt_temp;
    logic                nxt_start;
    logic [N_STAGES-1:0] nxt_red;
    logic                nxt_edit_led;

    always_comb begin
        nxt_state     = state;
        nxt_mask      = sel_stage_mask;
        nxt_level     = green_led_level;
        nxt_temp      = green_led_temp;
        nxt_start     = 1'b0;
        nxt_blink_cnt = blink_cnt + BL_W'(1);
        nxt_phase     = phase;
        if (blink_cnt == BL_LAST) begin
            nxt_blink_cnt = '0;
            nxt_phase     = ~phase;
        end
        case (state)
            IDLE: begin
                if (press[0])
                    nxt_mask = (sel_stage_mask == '1) ? N_STAGES'(1) : sel_stage_mask + N_STAGES'(1);
                if (press[1])
                    nxt_level = {green_led_level[N_LEVELS-2:0], green_led_level[N_LEVELS-1]};
                if (press[2])
                    nxt_temp = {green_led_temp[N_TEMPS-2:0], green_led_temp[N_TEMPS-1]};
                if (press[3]) begin
                    nxt_state     = RUN;
                    nxt_start     = 1'b1;
                    nxt_blink_cnt = '0;
                    nxt_phase     = 1'b1;
                end
            end
            RUN: begin
                if (run_done)      nxt_state = IDLE;
                else if (press[3]) nxt_state = PAUSE;
            end
            PAUSE: begin
                if (run_done)      nxt_state = IDLE;
                else if (press[3]) nxt_state = RUN;
            end
            default: nxt_state = IDLE;
        endcase

        // LEDs are derived from next-cycle values so every output lands on the same edge
        nxt_red      = nxt_mask;
        nxt_edit_led = 1'b1;
        if (nxt_state == RUN) begin
            nxt_red      = (nxt_mask & ~run_stage) | (run_stage & {N_STAGES{nxt_phase}});
            nxt_edit_led = 1'b0;
        end else if (nxt_state == PAUSE) begin
            nxt_red      = nxt_mask | run_stage;
            nxt_edit_led = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            blink_cnt            <= '0;
            phase                <= 1'b0;
            sel_stage_mask       <= '1;
            green_led_level      <= N_LEVELS'(1);
            green_led_temp       <= N_TEMPS'(1);
            start_pulse          <= 1'b0;
            pause                <= 1'b0;
            red_led_stage        <= '1;
            red_led_water_height <= 1'b1;
            red_led_hot_cold     <= 1'b1;
        end else begin
            state                <= nxt_state;
            blink_cnt            <= nxt_blink_cnt;
            phase                <= nxt_phase;
            sel_stage_mask       <= nxt_mask;
            green_led_level      <= nxt_level;
            green_led_temp       <= nxt_temp;
            start_pulse          <= nxt_start;
            pause                <= (nxt_state == PAUSE);
            red_led_stage        <= nxt_red;
            red_led_water_height <= nxt_edit_led;
            red_led_hot_cold     <= nxt_edit_led;
        end
    end
endmodule
